// File: rtl/div_pkg.sv
// Shared encodings and constants for the iterative radix-2 restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  // Remainder occupies the low half of the result word, quotient the high half.
  localparam int REM_LSB = 0;

  function automatic int div_quo_lsb(input int width);
    return width;
  endfunction

  // Cycles from the accept edge to the edge that starts the result pulse.
  function automatic int div_latency(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract the divisor.
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] diff_s;
  logic           fits_s;
  logic           unused_s;

  assign shifted_s = {rem_in, quo_in[WIDTH-1]};
  assign diff_s    = shifted_s - {1'b0, divisor};
  assign fits_s    = (shifted_s >= {1'b0, divisor});
  // Top difference bit is always zero when the subtraction is kept.
  assign unused_s  = diff_s[WIDTH];

  // Restore (keep shifted value) or commit the subtraction and set the quotient bit.
  always_comb begin
    rem_out = shifted_s[WIDTH-1:0];
    quo_out = {quo_in[WIDTH-2:0], 1'b0};
    if (fits_s) begin
      rem_out = diff_s[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b1};
    end else begin
      rem_out = shifted_s[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_radix2_core.sv
// Iterative radix-2 restoring divider with stream-style operand handshake and
// a one-cycle result pulse carrying {quotient, remainder}.
module div_radix2_core
  import div_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_axis_dividend_tvalid,
  output logic               s_axis_dividend_tready,
  input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
  input  logic               s_axis_divisor_tvalid,
  output logic               s_axis_divisor_tready,
  input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
  output logic               m_axis_dout_tvalid,
  output logic [2*WIDTH-1:0] m_axis_dout_tdata
);

  localparam int CW      = $clog2(WIDTH) + 1;
  localparam int QUO_LSB = div_quo_lsb(WIDTH);
  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    ONE_C = {{(CW-1){1'b0}}, 1'b1};

  div_state_e         state_r, state_nxt_s;
  logic [CW-1:0]      cnt_r;
  logic [WIDTH-1:0]   rem_r, quo_r, div_r;
  logic               sign_q_r, sign_r_r;
  logic               tvalid_r;
  logic [2*WIDTH-1:0] tdata_r;
  logic               accept_s, a_neg_s, b_neg_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s;
  logic [WIDTH-1:0]   rem_step_s, quo_step_s, quo_fix_s, rem_fix_s;

  assign s_axis_dividend_tready = (state_r == ST_IDLE) && !reset;
  assign s_axis_divisor_tready  = (state_r == ST_IDLE) && !reset;
  assign accept_s = (state_r == ST_IDLE) && s_axis_dividend_tvalid
                    && s_axis_divisor_tvalid && !reset;
  assign m_axis_dout_tvalid = tvalid_r;
  assign m_axis_dout_tdata  = tdata_r;

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_r),
    .quo_in  (quo_r),
    .divisor (div_r),
    .rem_out (rem_step_s),
    .quo_out (quo_step_s)
  );

  // Operand signs and magnitudes; unsigned instances treat every operand as positive.
  always_comb begin
    a_neg_s = 1'b0;
    b_neg_s = 1'b0;
    if (SIGNED) begin
      a_neg_s = s_axis_dividend_tdata[WIDTH-1];
      b_neg_s = s_axis_divisor_tdata[WIDTH-1];
    end else begin
      a_neg_s = 1'b0;
      b_neg_s = 1'b0;
    end
    if (a_neg_s) a_mag_s = ~s_axis_dividend_tdata + ONE_W;
    else         a_mag_s = s_axis_dividend_tdata;
    if (b_neg_s) b_mag_s = ~s_axis_divisor_tdata + ONE_W;
    else         b_mag_s = s_axis_divisor_tdata;
  end

  // Sign correction applied to the magnitude results.
  always_comb begin
    quo_fix_s = quo_r;
    rem_fix_s = rem_r;
    if (SIGNED && sign_q_r) quo_fix_s = ~quo_r + ONE_W;
    else                    quo_fix_s = quo_r;
    if (SIGNED && sign_r_r) rem_fix_s = ~rem_r + ONE_W;
    else                    rem_fix_s = rem_r;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_nxt_s;
  end

  // Next state; CALC exits once the counter has wrapped past zero after the last step.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: if (accept_s) state_nxt_s = ST_CALC;
               else          state_nxt_s = ST_IDLE;
      ST_CALC: if (cnt_r[CW-1]) state_nxt_s = ST_FIX;
               else             state_nxt_s = ST_CALC;
      ST_FIX:  state_nxt_s = ST_DONE;
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, and registered result.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r    <= {CW{1'b0}};
      rem_r    <= {WIDTH{1'b0}};
      quo_r    <= {WIDTH{1'b0}};
      div_r    <= {WIDTH{1'b0}};
      sign_q_r <= 1'b0;
      sign_r_r <= 1'b0;
      tvalid_r <= 1'b0;
      tdata_r  <= {(2*WIDTH){1'b0}};
    end else begin
      tvalid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            rem_r    <= {WIDTH{1'b0}};
            quo_r    <= a_mag_s;
            div_r    <= b_mag_s;
            sign_q_r <= a_neg_s ^ b_neg_s;
            sign_r_r <= a_neg_s;
            cnt_r    <= CW'(WIDTH - 1);
          end
        end
        ST_CALC: begin
          if (!cnt_r[CW-1]) begin
            rem_r <= rem_step_s;
            quo_r <= quo_step_s;
            cnt_r <= cnt_r - ONE_C;
          end
        end
        ST_FIX: begin
          tdata_r[QUO_LSB +: WIDTH] <= quo_fix_s;
          tdata_r[REM_LSB +: WIDTH] <= rem_fix_s;
          tvalid_r <= 1'b1;
        end
        ST_DONE: tvalid_r <= 1'b0;
        default: tvalid_r <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_div_radix2_core.sv
// Self-checking bench: unsigned and signed divider instances share stimulus and
// are compared against plain-arithmetic reference results.
module tb_div_radix2_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dvd_valid = 1'b0, dvs_valid = 1'b0;
  logic [31:0] dvd_data = 32'd0, dvs_data = 32'd0;
  logic        dvd_rdy_uns, dvs_rdy_uns, tv_uns;
  logic        dvd_rdy_sgn, dvs_rdy_sgn, tv_sgn;
  logic [63:0] dout_uns, dout_sgn;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  div_radix2_core #(.WIDTH(32), .SIGNED(1'b0)) u_dut_uns (
    .clk(clk), .reset(reset),
    .s_axis_dividend_tvalid(dvd_valid), .s_axis_dividend_tready(dvd_rdy_uns),
    .s_axis_dividend_tdata(dvd_data),
    .s_axis_divisor_tvalid(dvs_valid), .s_axis_divisor_tready(dvs_rdy_uns),
    .s_axis_divisor_tdata(dvs_data),
    .m_axis_dout_tvalid(tv_uns), .m_axis_dout_tdata(dout_uns)
  );

  div_radix2_core #(.WIDTH(32), .SIGNED(1'b1)) u_dut_sgn (
    .clk(clk), .reset(reset),
    .s_axis_dividend_tvalid(dvd_valid), .s_axis_dividend_tready(dvd_rdy_sgn),
    .s_axis_dividend_tdata(dvd_data),
    .s_axis_divisor_tvalid(dvs_valid), .s_axis_divisor_tready(dvs_rdy_sgn),
    .s_axis_divisor_tdata(dvs_data),
    .m_axis_dout_tvalid(tv_sgn), .m_axis_dout_tdata(dout_sgn)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_uns(input logic [31:0] a, input logic [31:0] b);
    longint unsigned ua, ub, q, r;
    logic [63:0] qv, rv;
    ua = a; ub = b;
    if (ub == 0) return {32'hFFFFFFFF, a};
    q = ua / ub; r = ua % ub;
    qv = q; rv = r;
    return {qv[31:0], rv[31:0]};
  endfunction

  function automatic logic [63:0] ref_sgn(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] qv, rv;
    sa = $signed(a); sb = $signed(b);
    if (sb == 0) return {(sa < 0) ? 32'd1 : 32'hFFFFFFFF, a};
    q = sa / sb; r = sa % sb;
    qv = q; rv = r;
    return {qv[31:0], rv[31:0]};
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'h0000_0000;
      1: v = 32'h8000_0000;
      2: v = 32'hFFFF_FFFF;
      3: v = $urandom_range(0, 15);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] rdys();
    return {dvd_rdy_uns, dvs_rdy_uns, dvd_rdy_sgn, dvs_rdy_sgn};
  endfunction

  // One full transaction; operands are scrambled after the accept edge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b);
    int n;
    logic [63:0] eu, es;
    eu = ref_uns(a, b);
    es = ref_sgn(a, b);
    @(negedge clk);
    chk("tready_idle", {60'd0, rdys()}, 64'hF);
    dvd_data = a; dvs_data = b; dvd_valid = 1'b1; dvs_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dvd_valid = 1'b0; dvs_valid = 1'b0;
    dvd_data = $urandom; dvs_data = $urandom;
    chk("tready_busy", {60'd0, rdys()}, 64'h0);
    n = 0;
    while (!tv_uns && n < 60) begin
      @(negedge clk);
      n++;
      dvd_data = $urandom; dvs_data = $urandom;
    end
    chk("latency", 64'(n), 64'd34);
    chk("tvalid_both", {62'd0, tv_uns, tv_sgn}, 64'd3);
    chk("result_uns", dout_uns, eu);
    chk("result_sgn", dout_sgn, es);
    @(negedge clk);
    chk("pulse_end", {59'd0, tv_uns, tv_sgn, rdys() == 4'hF, 2'b00}, {59'd0, 5'b00100});
  endtask

  initial begin
    int n, n2;
    logic [3:0] rdy1, rdy2;
    logic seen;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset_tvalid", {62'd0, tv_uns, tv_sgn}, 64'd0);
    chk("reset_tdata_uns", dout_uns, 64'd0);
    chk("reset_tdata_sgn", dout_sgn, 64'd0);
    chk("reset_tready", {60'd0, rdys()}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_tready", {60'd0, rdys()}, 64'hF);

    // Directed values.
    run_op(32'd100, 32'd7);
    chk("u_100_7", dout_uns, {32'd14, 32'd2});
    run_op(32'hFFFF_FFF9, 32'd2);
    chk("s_m7_2", dout_sgn, {32'hFFFF_FFFD, 32'hFFFF_FFFF});
    run_op(32'd7, 32'hFFFF_FFFE);
    chk("s_7_m2", dout_sgn, {32'hFFFF_FFFD, 32'd1});
    run_op(32'h8000_0000, 32'hFFFF_FFFF);
    chk("s_min_m1", dout_sgn, {32'h8000_0000, 32'd0});
    run_op(32'd5, 32'd0);
    chk("u_5_0", dout_uns, {32'hFFFF_FFFF, 32'd5});
    run_op(32'hFFFF_FFFB, 32'd0);
    chk("s_m5_0", dout_sgn, {32'd1, 32'hFFFF_FFFB});

    // Dividend valid alone is never accepted.
    seen = 1'b0;
    @(negedge clk);
    dvd_data = 32'd40; dvs_data = 32'd4; dvd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rdys() != 4'hF || tv_uns || tv_sgn) seen = 1'b1;
    end
    dvd_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tv_uns || tv_sgn) seen = 1'b1;
    end
    chk("single_valid_ignored", {63'd0, seen}, 64'd0);

    // Valid held high: next accept one cycle after the pulse, pulses 36 apart.
    @(negedge clk);
    dvd_data = 32'd50; dvs_data = 32'd5; dvd_valid = 1'b1; dvs_valid = 1'b1;
    @(posedge clk);
    n = 0;
    @(negedge clk);
    while (!tv_uns && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("held_latency", 64'(n), 64'd34);
    chk("held_result1", dout_uns, {32'd10, 32'd0});
    dvd_data = 32'd77; dvs_data = 32'd8;
    n2 = 0; rdy1 = 4'h0; rdy2 = 4'hF;
    do begin
      @(negedge clk);
      n2++;
      if (n2 == 1) rdy1 = rdys();
      if (n2 == 2) rdy2 = rdys();
    end while (!tv_uns && n2 < 60);
    dvd_valid = 1'b0; dvs_valid = 1'b0;
    chk("held_gap", 64'(n2), 64'd36);
    chk("held_rdy_after_done", {60'd0, rdy1}, 64'hF);
    chk("held_rdy_after_accept", {60'd0, rdy2}, 64'h0);
    chk("held_result2_uns", dout_uns, ref_uns(32'd77, 32'd8));
    chk("held_result2_sgn", dout_sgn, ref_sgn(32'd77, 32'd8));
    repeat (2) @(negedge clk);

    // Reset during CALC aborts the operation silently.
    dvd_data = 32'd12345; dvs_data = 32'd67; dvd_valid = 1'b1; dvs_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dvd_valid = 1'b0; dvs_valid = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_tready", {60'd0, rdys()}, 64'hF);
    chk("abort_tdata", dout_uns | dout_sgn, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tv_uns || tv_sgn) seen = 1'b1;
    end
    chk("abort_no_pulse", {63'd0, seen}, 64'd0);
    run_op(32'd9, 32'd3);
    chk("after_abort_9_3", dout_uns, {32'd3, 32'd0});

    // Reset coinciding with valid: no accept.
    @(negedge clk);
    reset = 1'b1; dvd_valid = 1'b1; dvs_valid = 1'b1;
    @(negedge clk);
    reset = 1'b0; dvd_valid = 1'b0; dvs_valid = 1'b0;
    @(negedge clk);
    chk("reset_with_valid", {60'd0, rdys()}, 64'hF);

    // Random sweep against the reference model.
    for (int i = 0; i < 1200; i++) begin
      run_op(pick(), pick());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
